// File: rtl/digitron_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package digitron_pkg;

   // Largest value the six-digit display can show.
   localparam logic [19:0] DISP_MAX = 20'd999999;

   // Owner index width; covers up to 8 requesters.
   localparam int OWNER_W = 3;

   // Per-requester field widths: binary value, decimal points, blink mask.
   localparam int NUM_W   = 20;
   localparam int POINT_W = 6;
   localparam int SHANK_W = 6;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

endpackage

// File: rtl/digitron_prio_enc.sv
// Highest-set-index encoder with a valid flag.
// Latency: combinational.
// Backpressure: none.
module digitron_prio_enc
   import digitron_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]       vec,
   output logic [OWNER_W-1:0] idx,
   output logic               vld
);

   // Scan upward so the highest set bit is the last one written.
   always_comb begin
      idx = '0;
      for (int i = 0; i < N; i++) begin
         if (vec[i]) idx = OWNER_W'(i);
      end
   end

   assign vld = |vec;

endmodule

// File: rtl/digitron_arbiter.sv
// Shares one six-digit display between a background source and priority pop-ups.
// Latency: request/release sampled at an edge is reflected on all outputs at that edge's register update (1 cycle).
// Backpressure: none; losing requests are queued in a pending mask, never stalled.
module digitron_arbiter
   import digitron_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int HOLD_MS = 2000
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NREQ-1:0]           req,
   input  logic [NUM_W*NREQ-1:0]     num_in,
   input  logic [POINT_W*NREQ-1:0]   point_in,
   input  logic [SHANK_W*NREQ-1:0]   shank_in,
   input  logic [NREQ-1:0]           release_in,
   output logic [NUM_W-1:0]          number_out,
   output logic [POINT_W-1:0]        point_out,
   output logic [SHANK_W-1:0]        shank_out,
   output logic [OWNER_W-1:0]        owner,
   output logic                      busy,
   output logic                      overflow
);

   localparam int              TW       = (HOLD_MS > 1) ? $clog2(HOLD_MS) : 1;
   localparam logic [TW-1:0]   T_LOAD   = TW'(HOLD_MS - 1);
   // Requester 0 is the background and never requests or releases.
   localparam logic [NREQ-1:0] REQ_MASK = {{(NREQ-1){1'b1}}, 1'b0};

   state_t              state, state_nxt;
   logic [OWNER_W-1:0]  owner_nxt;
   logic [NREQ-1:0]     pend, pend_nxt;
   logic [TW-1:0]       timer, timer_nxt;

   logic [NREQ-1:0]     req_eff, rel_eff, cand, own_oh;
   logic [OWNER_W-1:0]  req_idx, cand_idx;
   logic                req_vld, cand_vld, hold_end;

   logic [NUM_W-1:0]    sel_num;
   logic [POINT_W-1:0]  sel_point;
   logic [SHANK_W-1:0]  sel_shank;
   logic                sel_ovf;

   assign req_eff = req & REQ_MASK;
   assign rel_eff = release_in & REQ_MASK;
   assign own_oh  = NREQ'(1) << owner;
   // At hold end, fresh requests compete together with the queued ones.
   assign cand    = (pend | req_eff) & ~rel_eff;
   assign hold_end = (state == HOLD) && ((timer == '0) || (|(rel_eff & own_oh)));

   digitron_prio_enc #(.N(NREQ)) u_enc_req (
      .vec (req_eff),
      .idx (req_idx),
      .vld (req_vld)
   );

   digitron_prio_enc #(.N(NREQ)) u_enc_cand (
      .vec (cand),
      .idx (cand_idx),
      .vld (cand_vld)
   );

   // Next owner, pending mask and hold timer.
   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      pend_nxt  = pend;
      timer_nxt = timer;
      if (state == IDLE) begin
         owner_nxt = '0;
         timer_nxt = '0;
         pend_nxt  = pend & ~rel_eff;
         if (req_vld) begin
            state_nxt = HOLD;
            owner_nxt = req_idx;
            timer_nxt = T_LOAD;
            pend_nxt  = (pend | req_eff) & ~(NREQ'(1) << req_idx) & ~rel_eff;
         end
      end else if (hold_end) begin
         if (cand_vld) begin
            owner_nxt = cand_idx;
            timer_nxt = T_LOAD;
            pend_nxt  = cand & ~(NREQ'(1) << cand_idx);
         end else begin
            state_nxt = IDLE;
            owner_nxt = '0;
            timer_nxt = '0;
            pend_nxt  = '0;
         end
      end else if (req_vld && (req_idx > owner)) begin
         // Preemption: the displaced owner is dropped, not re-queued.
         owner_nxt = req_idx;
         timer_nxt = T_LOAD;
         pend_nxt  = (pend | (req_eff & ~own_oh)) & ~(NREQ'(1) << req_idx) & ~rel_eff;
      end else begin
         timer_nxt = (|(req_eff & own_oh)) ? T_LOAD : (timer - TW'(1));
         pend_nxt  = (pend | (req_eff & ~own_oh)) & ~rel_eff;
      end
   end

   // Pick the next owner's live fields so data lines up with the owner register.
   always_comb begin
      sel_num   = '0;
      sel_point = '0;
      sel_shank = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (owner_nxt == OWNER_W'(i)) begin
            sel_num   = num_in[i*NUM_W +: NUM_W];
            sel_point = point_in[i*POINT_W +: POINT_W];
            sel_shank = shank_in[i*SHANK_W +: SHANK_W];
         end
      end
      sel_ovf = (sel_num > DISP_MAX);
   end

   // Control state and registered display outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         owner      <= '0;
         pend       <= '0;
         timer      <= '0;
         number_out <= '0;
         point_out  <= '0;
         shank_out  <= '0;
         overflow   <= 1'b0;
      end else begin
         state      <= state_nxt;
         owner      <= owner_nxt;
         pend       <= pend_nxt;
         timer      <= timer_nxt;
         number_out <= sel_ovf ? DISP_MAX : sel_num;
         point_out  <= sel_point;
         // A clamped value blinks every digit as an out-of-range cue.
         shank_out  <= sel_ovf ? '1 : sel_shank;
         overflow   <= sel_ovf;
      end
   end

   assign busy = (state == HOLD);

endmodule
